grey2raw_upsampler: RTL and testbench

- Reverse-direction partner of the camera grey path.
- Takes the half-resolution grey stream (one sample per 2x2 Bayer cell, raster order) and re-expands it to a full-resolution raw-format stream with pixel coordinates.
- Output is shaped like the sensor capture stream: data, valid, X/Y counters. Downstream raw consumers (line buffers, demosaic, display writers) can be fed from synthetic or processed grey frames.
- Each grey sample is replicated 2x horizontally. Each grey line is replayed 2x vertically from an internal line RAM.

---
 rtl/grey2raw_upsampler_if.sv | 25 ++
 rtl/grey2raw_upsampler.sv | 141 ++++++++++++++
 tb/tb_grey2raw_upsampler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/grey2raw_upsampler_if.sv
// Stream bundle for the grey-to-raw upsampler: grey input handshake plus the
// raw-format output stream with pixel coordinates.
interface grey2raw_upsampler_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] iGrey;
    logic              iDVAL;
    logic              oREADY;
    logic [DATA_W-1:0] oDATA;
    logic              oDVAL;
    logic              iREADY;
    logic [10:0]       oX_Cont;
    logic [10:0]       oY_Cont;
    logic              oFRAME_END;

    modport slave (
        input  iGrey, iDVAL, iREADY,
        output oREADY, oDATA, oDVAL, oX_Cont, oY_Cont, oFRAME_END
    );

    modport master (
        output iGrey, iDVAL, iREADY,
        input  oREADY, oDATA, oDVAL, oX_Cont, oY_Cont, oFRAME_END
    );
endinterface

// File: rtl/grey2raw_upsampler.sv
// Re-expands a half-resolution grey stream into a full-resolution raw stream:
// each sample is emitted twice per line and each line is replayed from a line RAM.
module grey2raw_upsampler #(
    parameter int IN_WIDTH  = 640,
    parameter int IN_HEIGHT = 480,
    parameter int DATA_W    = 12
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    grey2raw_upsampler_if.slave  bus
);
    localparam int          AW     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [10:0] LAST_X = 11'(2 * IN_WIDTH - 1);
    localparam logic [10:0] LAST_Y = 11'(2 * IN_HEIGHT - 1);

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_phase;
    logic [10:0]       r_col;
    logic [10:0]       r_row;
    logic [DATA_W-1:0] r_odata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_odval;
    logic              r_fend;
    logic [10:0]       r_ox;
    logic [10:0]       r_oy;
    logic [DATA_W-1:0] r_ram [0:(1 << AW) - 1];

    logic              w_slot_free;
    logic              w_ready;
    logic              w_in_xfer;
    logic              w_last_x;
    logic              w_last_y;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic              w_we;
    logic              w_re;
    logic [AW-1:0]     w_raddr;

    assign w_slot_free = !r_odval | bus.iREADY;
    assign w_ready     = (r_state == ROW_EVEN) & !r_phase & w_slot_free;
    assign w_in_xfer   = bus.iDVAL & w_ready;
    assign w_last_x    = (r_col == LAST_X);
    assign w_last_y    = (r_row == LAST_Y);

    // Decide what gets loaded into the output register this cycle and drive the line RAM ports.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = r_odata;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_raddr     = '0;
        case (r_state)
            ROW_EVEN: begin
                if (!r_phase) begin
                    w_load      = w_in_xfer;
                    w_load_data = bus.iGrey;
                    w_we        = w_in_xfer;
                end else begin
                    w_load      = w_slot_free;
                    w_load_data = r_odata;
                    // Fetch entry 0 while the last even-row pixel loads, so the odd row starts without a gap.
                    w_re        = w_slot_free & w_last_x;
                    w_raddr     = '0;
                end
            end
            ROW_ODD: begin
                w_load = w_slot_free;
                if (!r_col[0]) begin
                    w_load_data = r_rdata;
                    w_re        = w_slot_free;
                    w_raddr     = r_col[AW:1] + AW'(1);
                end else begin
                    w_load_data = r_odata;
                end
            end
            default: begin
                w_load      = 1'b0;
                w_load_data = r_odata;
            end
        endcase
    end

    // Line RAM: written during even rows, read one entry ahead during odd rows.
    always_ff @(posedge iCLK) begin
        if (w_we) begin
            r_ram[r_col[AW:1]] <= bus.iGrey;
        end
        if (w_re) begin
            r_rdata <= r_ram[w_raddr];
        end
    end

    // Row/column sequencing and the output register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ROW_EVEN;
            r_phase <= 1'b0;
            r_col   <= 11'd0;
            r_row   <= 11'd0;
            r_odata <= '0;
            r_odval <= 1'b0;
            r_fend  <= 1'b0;
            r_ox    <= 11'd0;
            r_oy    <= 11'd0;
        end else if (w_load) begin
            r_odval <= 1'b1;
            r_odata <= w_load_data;
            r_ox    <= r_col;
            r_oy    <= r_row;
            r_fend  <= w_last_x & w_last_y;
            r_phase <= (r_state == ROW_EVEN) ? ~r_phase : 1'b0;
            if (w_last_x) begin
                r_col <= 11'd0;
                if (r_state == ROW_EVEN) begin
                    r_state <= ROW_ODD;
                    r_row   <= r_row + 11'd1;
                end else begin
                    r_state <= ROW_EVEN;
                    r_row   <= w_last_y ? 11'd0 : r_row + 11'd1;
                end
            end else begin
                r_col <= r_col + 11'd1;
            end
        end else if (bus.iREADY) begin
            r_odval <= 1'b0;
            r_fend  <= 1'b0;
        end
    end

    assign bus.oREADY     = w_ready;
    assign bus.oDATA      = r_odata;
    assign bus.oDVAL      = r_odval;
    assign bus.oX_Cont    = r_ox;
    assign bus.oY_Cont    = r_oy;
    assign bus.oFRAME_END = r_fend;
endmodule

// File: tb/tb_grey2raw_upsampler.sv
// Directed bench for grey2raw_upsampler on a 4x2 grey frame (8x4 raw output).
module tb_grey2raw_upsampler;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grey2raw_upsampler_if #(.DATA_W(DW)) bus ();

    grey2raw_upsampler #(
        .IN_WIDTH (W),
        .IN_HEIGHT(H),
        .DATA_W   (DW)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    logic [DW-1:0] in_seq [16];
    // Expected oREADY per cycle under continuous traffic: alternating in even rows, low in odd rows.
    logic [15:0]   ready_pat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.iDVAL  = 1'b0;
        bus.iGrey  = '0;
        bus.iREADY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run(input int nframes, input bit use_lfsr, output int last_cyc);
        int total_out = nframes * 32;
        int total_in  = nframes * 8;
        int in_idx    = 0;
        int out_idx   = 0;
        int cyc       = 0;
        int f, m, x, y;
        logic [15:0]   lf = 16'hACE1;
        bit            held = 1'b0;
        logic [DW-1:0] hd = '0;
        logic [10:0]   hx = 11'd0;
        logic [10:0]   hy = 11'd0;
        last_cyc = -1;
        while (out_idx < total_out && cyc < 400) begin
            if (use_lfsr) begin
                bus.iREADY = lf[0];
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            end else begin
                bus.iREADY = 1'b1;
            end
            bus.iDVAL = (in_idx < total_in);
            bus.iGrey = (in_idx < total_in) ? in_seq[in_idx] : '0;
            #1;
            if (held) begin
                chk("hold_dval", bus.oDVAL, 1);
                chk("hold_data", bus.oDATA, hd);
                chk("hold_x", bus.oX_Cont, hx);
                chk("hold_y", bus.oY_Cont, hy);
            end
            if (!use_lfsr) chk("ready_pattern", bus.oREADY, ready_pat[cyc % 16]);
            if (bus.oDVAL && bus.iREADY) begin
                f = out_idx / 32;
                m = out_idx % 32;
                y = m / 8;
                x = m % 8;
                chk("out_data", bus.oDATA, in_seq[f * 8 + (y / 2) * 4 + x / 2]);
                chk("out_x", bus.oX_Cont, x);
                chk("out_y", bus.oY_Cont, y);
                chk("out_frame_end", bus.oFRAME_END, (x == 7 && y == 3) ? 1 : 0);
                out_idx++;
                last_cyc = cyc;
            end
            if (bus.iDVAL && bus.oREADY) in_idx++;
            held = bus.oDVAL && !bus.iREADY;
            hd   = bus.oDATA;
            hx   = bus.oX_Cont;
            hy   = bus.oY_Cont;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("output_count", out_idx, total_out);
        chk("input_count", in_idx, total_in);
        bus.iDVAL  = 1'b0;
        bus.iREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("no_extra_output", bus.oDVAL, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  lc;
        int  idx;
        bit  found;
        in_seq    = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd70, 12'd80,
                      12'd11, 12'd21, 12'd31, 12'd41, 12'd51, 12'd61, 12'd71, 12'd81};
        ready_pat = 16'h0055;

        // Reset state.
        do_reset();
        chk("rst_dval", bus.oDVAL, 0);
        chk("rst_data", bus.oDATA, 0);
        chk("rst_x", bus.oX_Cont, 0);
        chk("rst_y", bus.oY_Cont, 0);
        chk("rst_frame_end", bus.oFRAME_END, 0);
        bus.iREADY = 1'b1;
        #1;
        chk("rst_ready", bus.oREADY, 1);

        // One frame with continuous traffic, also the throughput bound.
        run(1, 1'b0, lc);
        chk("throughput_34", (lc >= 0 && lc <= 34) ? 1 : 0, 1);

        // Same frame with downstream back-pressure.
        do_reset();
        run(1, 1'b1, lc);

        // Two back-to-back frames: frame end and wrap to X=0,Y=0.
        do_reset();
        run(2, 1'b0, lc);

        // Reset while the odd row is replaying at X=5.
        do_reset();
        idx   = 0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            bus.iREADY = 1'b1;
            bus.iDVAL  = (idx < 4);
            bus.iGrey  = (idx < 4) ? in_seq[idx] : '0;
            #1;
            if (bus.oDVAL && bus.oY_Cont == 11'd1 && bus.oX_Cont == 11'd5) begin
                found = 1'b1;
            end else begin
                if (bus.iDVAL && bus.oREADY) idx++;
                @(posedge clk);
                #1;
            end
        end
        chk("reach_odd_x5", found, 1);
        chk("odd_x5_data", bus.oDATA, 30);
        rst       = 1'b1;
        bus.iDVAL = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_dval", bus.oDVAL, 0);
        chk("midrst_data", bus.oDATA, 0);
        chk("midrst_x", bus.oX_Cont, 0);
        chk("midrst_y", bus.oY_Cont, 0);
        chk("midrst_frame_end", bus.oFRAME_END, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_replay", bus.oDVAL, 0);
        end
        chk("midrst_ready", bus.oREADY, 1);
        bus.iDVAL = 1'b1;
        bus.iGrey = 12'd99;
        @(posedge clk);
        #1;
        bus.iDVAL = 1'b0;
        chk("post_rst_dval", bus.oDVAL, 1);
        chk("post_rst_data", bus.oDATA, 99);
        chk("post_rst_x", bus.oX_Cont, 0);
        chk("post_rst_y", bus.oY_Cont, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
